// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, data-enable
// and line/frame strobes, all advancing on the pixel-rate enable.
module video_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FRONT  = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BACK   = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FRONT  = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BACK   = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] xpos,
   output logic [CNT_W-1:0] ypos,
   output logic             line_start,
   output logic             frame_start,
   output logic [7:0]       frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
       V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
       (2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_param_check
      $error("video_timing_gen: zero timing parameter or CNT_W too narrow");
   end

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

   logic             x_wrap;
   logic             y_wrap;
   logic [CNT_W-1:0] nx;
   logic [CNT_W-1:0] ny;

   // Syncs and de are decoded from the next position so they land in the
   // same register stage as xpos/ypos.
   always_comb begin
      x_wrap = (xpos == H_LAST);
      y_wrap = (ypos == V_LAST);
      nx     = x_wrap ? '0 : xpos + CNT_W'(1);
      ny     = ypos;
      if (x_wrap) begin
         ny = y_wrap ? '0 : ypos + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xpos        <= H_LAST;
         ypos        <= V_LAST;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_en) begin
            xpos        <= nx;
            ypos        <= ny;
            hsync       <= (nx >= HS_START && nx < HS_END) ? H_POL : ~H_POL;
            vsync       <= (ny >= VS_START && ny < VS_END) ? V_POL : ~V_POL;
            de          <= (nx < H_ACT) && (ny < V_ACT);
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
            if (x_wrap && y_wrap) begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-raster instance checked every cycle against
// a position-index model, plus a default-timing instance with positive syncs.
module tb_video_timing_gen;

   localparam int HT  = 14;
   localparam int VT  = 8;
   localparam int TOT = HT * VT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pix_en = 1'b0;

   logic       hsync, vsync, de, line_start, frame_start;
   logic [3:0] xpos, ypos;
   logic [7:0] frame_cnt;

   logic       hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
   logic [9:0] xpos_b, ypos_b;
   logic [7:0] frame_cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .CNT_W(4)
   ) u_dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(hsync), .vsync(vsync), .de(de),
      .xpos(xpos), .ypos(ypos),
      .line_start(line_start), .frame_start(frame_start),
      .frame_cnt(frame_cnt)
   );

   video_timing_gen #(
      .H_POL(1'b1), .V_POL(1'b1)
   ) u_big (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
      .xpos(xpos_b), .ypos(ypos_b),
      .line_start(line_start_b), .frame_start(frame_start_b),
      .frame_cnt(frame_cnt_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: raster position as a single index into the frame.
   int m_idx   = TOT - 1;
   int m_fcnt  = 0;
   bit m_ls    = 0;
   bit m_fs    = 0;
   bit m_valid = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_idx   = TOT - 1;
         m_fcnt  = 0;
         m_ls    = 0;
         m_fs    = 0;
         m_valid = 1;
      end else if (pix_en) begin
         m_idx = (m_idx + 1) % TOT;
         m_ls  = (m_idx % HT) == 0;
         m_fs  = (m_idx == 0);
         if (m_idx == 0) m_fcnt = (m_fcnt + 1) % 256;
      end else begin
         m_ls = 0;
         m_fs = 0;
      end
   end

   always @(negedge clk) begin
      int x, y;
      if (m_valid) begin
         x = m_idx % HT;
         y = m_idx / HT;
         chk("xpos", int'(xpos), x);
         chk("ypos", int'(ypos), y);
         chk("hsync", int'(hsync), (x >= 10 && x < 13) ? 0 : 1);
         chk("vsync", int'(vsync), (y >= 5 && y < 7) ? 0 : 1);
         chk("de", int'(de), (x < 8 && y < 4) ? 1 : 0);
         chk("line_start", int'(line_start), int'(m_ls));
         chk("frame_start", int'(frame_start), int'(m_fs));
         chk("frame_cnt", int'(frame_cnt), m_fcnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs_lo, vs_lo, de_hi, ls_hi, hb_hi, deb_hi;
      int fs_at[$];
      int tg_at[$];

      rst = 1'b1;
      pix_en = 1'b0;
      step();
      step();
      chk("rst_xpos", int'(xpos), 13);
      chk("rst_ypos", int'(ypos), 7);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_de", int'(de), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_fcnt", int'(frame_cnt), 0);
      chk("rst_big_x", int'(xpos_b), 799);
      chk("rst_big_y", int'(ypos_b), 524);
      chk("rst_big_hsync", int'(hsync_b), 0);
      chk("rst_big_vsync", int'(vsync_b), 0);

      // Continuous pixel enable: first frame shape and big-raster first line.
      rst = 1'b0;
      pix_en = 1'b1;
      hs_lo = 0; vs_lo = 0; de_hi = 0; ls_hi = 0; hb_hi = 0; deb_hi = 0;
      for (int k = 1; k <= 800; k++) begin
         step();
         if (k == 1) begin
            chk("c1_xpos", int'(xpos), 0);
            chk("c1_ypos", int'(ypos), 0);
            chk("c1_de", int'(de), 1);
            chk("c1_fs", int'(frame_start), 1);
            chk("c1_ls", int'(line_start), 1);
            chk("c1_fcnt", int'(frame_cnt), 1);
            chk("c1_big_fs", int'(frame_start_b), 1);
         end
         if (k == 14) chk("c14_xpos", int'(xpos), 13);
         if (k == 15) begin
            chk("c15_xpos", int'(xpos), 0);
            chk("c15_ypos", int'(ypos), 1);
         end
         if (k <= TOT) begin
            hs_lo += (hsync == 1'b0) ? 1 : 0;
            vs_lo += (vsync == 1'b0) ? 1 : 0;
            de_hi += int'(de);
         end
         ls_hi  += int'(line_start);
         hb_hi  += int'(hsync_b);
         deb_hi += int'(de_b);
         if (frame_start) fs_at.push_back(k);
      end
      chk("frame_hsync_low", hs_lo, 24);
      chk("frame_vsync_low", vs_lo, 28);
      chk("frame_de_high", de_hi, 32);
      chk("line_starts_800", ls_hi, 58);
      chk("big_hsync_high_line", hb_hi, 96);
      chk("big_de_high_line", deb_hi, 640);
      chk("frame_starts_800", fs_at.size(), 8);
      if (fs_at.size() >= 3) begin
         chk("frame_period", fs_at[1] - fs_at[0], 112);
         chk("frame_period2", fs_at[2] - fs_at[1], 112);
      end
      chk("fcnt_800", int'(frame_cnt), 8);

      // Alternating enable: frame period doubles.
      for (int k = 0; k < 700; k++) begin
         pix_en = (k % 2 == 0);
         step();
         if (frame_start) tg_at.push_back(k);
      end
      chk("toggle_frame_starts", tg_at.size() >= 2 ? 1 : 0, 1);
      if (tg_at.size() >= 2) chk("toggle_period", tg_at[1] - tg_at[0], 224);

      // Reset in mid-frame at (5,2).
      pix_en = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 34; k++) step();
      chk("pre_rst_xpos", int'(xpos), 5);
      chk("pre_rst_ypos", int'(ypos), 2);
      rst = 1'b1;
      step();
      chk("mid_rst_xpos", int'(xpos), 13);
      chk("mid_rst_ypos", int'(ypos), 7);
      chk("mid_rst_de", int'(de), 0);
      chk("mid_rst_hsync", int'(hsync), 1);
      chk("mid_rst_vsync", int'(vsync), 1);
      chk("mid_rst_fcnt", int'(frame_cnt), 0);
      rst = 1'b0;
      step();
      chk("post_rst_fs", int'(frame_start), 1);
      chk("post_rst_fcnt", int'(frame_cnt), 1);

      // Frame counter wrap.
      for (int k = 0; k < TOT * 254; k++) step();
      chk("fcnt_255", int'(frame_cnt), 255);
      chk("fs_255", int'(frame_start), 1);
      for (int k = 0; k < TOT; k++) step();
      chk("fcnt_wrap", int'(frame_cnt), 0);
      chk("fs_wrap", int'(frame_start), 1);
      for (int k = 0; k < 20; k++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL provide parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL provide parameter H_SYNC, default 96, horizontal sync-pulse pixels.
REQ-004 SHALL provide parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 SHALL provide parameters V_ACTIVE, V_FRONT, V_SYNC, V_BACK, defaults 480, 10, 2, 33, same meanings in lines.
REQ-006 SHALL provide parameters H_POL and V_POL, default 0, giving the asserted sync level (0 = active-low).
REQ-007 SHALL provide parameter CNT_W, default 10, counter and position width.
REQ-008 SHALL provide port clk, input, 1, single clock; all logic on its rising edge.
REQ-009 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL provide port pix_en, input, 1, pixel-rate clock enable; timing advances only on cycles with pix_en=1.
REQ-011 SHALL provide ports hsync and vsync, output, 1 each, sync pulses at H_POL/V_POL.
REQ-012 SHALL provide port de, output, 1, high when the current position is inside both active regions.
REQ-013 SHALL provide ports xpos and ypos, output, CNT_W each, the current horizontal and vertical counts.
REQ-014 SHALL provide ports line_start and frame_start, output, 1 each, single-clk strobes.
REQ-015 SHALL provide port frame_cnt, output, 8, frame counter.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise; region order per line and frame SHALL be active, front porch, sync, back porch, starting at count 0.
REQ-017 Elaboration SHALL fail if any timing parameter is 0 or 2^CNT_W < max(H_TOTAL, V_TOTAL).
REQ-018 On a clk edge with pix_en=1: xpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and ypos SHALL increment; at ypos = V_TOTAL-1 with xpos wrapping, ypos SHALL wrap to 0.
REQ-019 On a clk edge with pix_en=0, xpos, ypos, hsync, vsync, de and frame_cnt SHALL hold.
REQ-020 hsync, vsync and de SHALL be registered and describe the same position as xpos/ypos in the same cycle; zero skew between them.
REQ-021 hsync SHALL be asserted iff H_ACTIVE+H_FRONT <= xpos < H_ACTIVE+H_FRONT+H_SYNC.
REQ-022 vsync SHALL be asserted iff V_ACTIVE+V_FRONT <= ypos < V_ACTIVE+V_FRONT+V_SYNC, changing only when xpos becomes 0.
REQ-023 de SHALL be 1 iff xpos < H_ACTIVE and ypos < V_ACTIVE.
REQ-024 line_start SHALL be 1 for exactly one clk cycle, the cycle after an advance that sets xpos to 0; 0 in all other cycles, including pix_en=0 cycles.
REQ-025 frame_start SHALL be 1 for exactly one clk cycle, the cycle after an advance to (0,0); line_start SHALL also be 1 in that cycle.
REQ-026 frame_cnt SHALL increment, modulo 256, on each advance to (0,0).
REQ-027 The block SHALL have no combinational path from any input to any output.

Reset
REQ-028 While rst=1, regardless of pix_en: xpos=H_TOTAL-1, ypos=V_TOTAL-1, hsync=!H_POL, vsync=!V_POL, de=0, line_start=0, frame_start=0, frame_cnt=0.
REQ-029 The first pix_en=1 edge after rst falls SHALL advance to (0,0): de=1, line_start=frame_start=1, frame_cnt=1.
REQ-030 rst asserted mid-line or mid-frame SHALL override pix_en and restore the REQ-028 state at the next edge.

Verification
Test parameters: H=8/2/3/1 (H_TOTAL 14), V=4/1/2/1 (V_TOTAL 8), pols 0, CNT_W 4.
REQ-031 rst 2 cycles, then pix_en=1 constant -> cycle 1: (0,0), de=1, frame_start=1; xpos wraps 13->0; frame_start recurs every 112 cycles; frame_cnt counts 1,2,3.
REQ-032 pix_en=1 constant -> hsync=0 exactly at xpos 10..12 on every line; vsync=0 exactly while ypos 5..6 (28 cycles); de high 32 of 112 cycles per frame.
REQ-033 pix_en toggling 1,0 -> all positions held on pix_en=0 cycles; frame period 224 clks; line_start width 1 clk.
REQ-034 rst pulse at (5,2) -> next cycle (13,7), de=0, syncs inactive, frame_cnt=0; next advance gives frame_start=1.
REQ-035 Defaults, H_POL=V_POL=1 -> hsync high 96 of 800 pixels; vsync high 2 of 525 lines; frame = 420000 advances.
REQ-036 frame_cnt after 256 frames -> wraps 255->0 on the advance to (0,0), frame_start=1 on that frame.
